// File: rtl/wb_pkg.sv
// Shared definitions for the data-cache write-back buffer.
//   LINE_OFFSET_BITS : byte offset bits inside a 32-byte line
//   WB_ADDR_W        : default byte address width
//   WB_LINE_W        : default line width in bits
//   wb_state_t       : drain FSM state
//   wb_entry_t       : one buffered line {valid, line tag, data}
package wb_pkg;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int WB_ADDR_W        = 32;
    localparam int WB_LINE_W        = 256;
    localparam int WB_TAG_W         = WB_ADDR_W - LINE_OFFSET_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_state_t;

    // The entry layout follows the package default widths; the top level
    // keeps its ADDR_W / LINE_W parameters at these defaults.
    typedef struct packed {
        logic                 valid;
        logic [WB_TAG_W-1:0]  tag;
        logic [WB_LINE_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Address comparator array for the write-back buffer.
// Compares one line tag against every entry and reports which entries match
// and which matching entry is the youngest (furthest from the head in FIFO
// order).
//   valid    in  per-entry valid (callers may pre-mask entries out)
//   tags     in  per-entry line tags
//   key      in  tag to search for
//   head     in  FIFO head pointer, the oldest entry
//   match    out per-entry match vector
//   youngest out index of the youngest match (head when nothing matches)
module wb_match #(
    parameter  int DEPTH = 4,
    parameter  int TAG_W = 27,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]            key,
    input  logic [PTR_W-1:0]            head,
    output logic [DEPTH-1:0]            match,
    output logic [PTR_W-1:0]            youngest
);

    logic [PTR_W-1:0] scan_idx;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (tags[i] == key);
        end
    end

    // Walk oldest to youngest starting at head; the last hit seen wins.
    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        youngest = head;
        scan_idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PTR_W'(k);
            if (match[scan_idx]) begin
                youngest = scan_idx;
            end
        end
    end

endmodule

// File: rtl/dc_wb_buffer.sv
// Write-back buffer between the data cache and main memory.
// Evicted dirty lines are queued in a circular FIFO and drained to memory
// one at a time over the block-write handshake. Buffered lines can be
// forwarded to cache refills, and the buffer reports when a flush may end.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-low reset
//   evict_valid/addr/data      line offered by the cache
//   evict_ready                room for another line (count < DEPTH)
//   lookup_addr                miss address to search for
//   lookup_hit/lookup_data     youngest matching line, data 0 on miss
//   dBlkWrite                  block-write request to memory
//   data_address_2DM           head line address while dBlkWrite, else 0
//   block_write_2DM            head line data while dBlkWrite, else 0
//   block_write_fDM_valid      memory accepted the current write
//   flush, flush_done          SYS flush request / buffer drained and idle
//   count                      occupied entries
//
// Drain FSM:
//   state | meaning
//   IDLE  | no write outstanding; launches a write when count != 0
//   WRITE | head line presented to memory, held until accepted
module dc_wb_buffer
    import wb_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = WB_ADDR_W,
    parameter  int LINE_W = WB_LINE_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1,
    localparam int TAG_W  = ADDR_W - LINE_OFFSET_BITS
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              evict_valid,
    input  logic [ADDR_W-1:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    output logic              evict_ready,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [LINE_W-1:0] lookup_data,
    output logic              dBlkWrite,
    output logic [ADDR_W-1:0] data_address_2DM,
    output logic [LINE_W-1:0] block_write_2DM,
    input  logic              block_write_fDM_valid,
    input  logic              flush,
    output logic              flush_done,
    output logic [CNT_W-1:0]  count
);

    wb_entry_t entries [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    wb_state_t        state;
    wb_state_t        state_next;

    logic [DEPTH-1:0]            valid_vec;
    logic [DEPTH-1:0][TAG_W-1:0] tag_vec;
    logic [DEPTH-1:0]            head_onehot;
    logic [DEPTH-1:0]            coal_valid;
    logic [DEPTH-1:0]            coal_match;
    logic [DEPTH-1:0]            look_match;
    logic [PTR_W-1:0]            coal_idx;
    logic [PTR_W-1:0]            look_idx;
    logic [TAG_W-1:0]            evict_tag;
    logic [TAG_W-1:0]            lookup_tag;
    logic                        coal_hit;
    logic                        push;
    logic                        pop;
    logic                        unused_offset_bits;

    assign evict_tag  = evict_addr[ADDR_W-1:LINE_OFFSET_BITS];
    assign lookup_tag = lookup_addr[ADDR_W-1:LINE_OFFSET_BITS];
    assign unused_offset_bits = ^{evict_addr[LINE_OFFSET_BITS-1:0],
                                  lookup_addr[LINE_OFFSET_BITS-1:0]};

    always_comb begin
        valid_vec   = '0;
        tag_vec     = '0;
        head_onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = entries[i].valid;
            tag_vec[i]   = entries[i].tag;
        end
        head_onehot[head] = 1'b1;
    end

    // The head being written must stay stable, so it is hidden from
    // coalescing while in WRITE; a repeat of that address gets a new entry.
    assign coal_valid = valid_vec & ~((state == WRITE) ? head_onehot : '0);

    wb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_coal_match (
        .valid    (coal_valid),
        .tags     (tag_vec),
        .key      (evict_tag),
        .head     (head),
        .match    (coal_match),
        .youngest (coal_idx)
    );

    wb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_look_match (
        .valid    (valid_vec),
        .tags     (tag_vec),
        .key      (lookup_tag),
        .head     (head),
        .match    (look_match),
        .youngest (look_idx)
    );

    assign coal_hit    = |coal_match;
    assign evict_ready = (count < CNT_W'(DEPTH));
    assign push        = evict_valid && evict_ready;
    assign pop         = (state == WRITE) && block_write_fDM_valid;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= IDLE;
        end else begin
            state <= state_next;
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            if (push) begin
                if (coal_hit) begin
                    entries[coal_idx].data <= evict_data;
                end else begin
                    entries[tail].valid <= 1'b1;
                    entries[tail].tag   <= evict_tag;
                    entries[tail].data  <= evict_data;
                    tail                <= tail + 1'b1;
                end
            end
            case ({push && !coal_hit, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = WRITE;
            WRITE:   if (block_write_fDM_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // dBlkWrite is the state register itself, so it is glitch-free and
    // clears asynchronously with reset.
    assign dBlkWrite        = (state == WRITE);
    assign data_address_2DM = dBlkWrite ? {entries[head].tag, {LINE_OFFSET_BITS{1'b0}}} : '0;
    assign block_write_2DM  = dBlkWrite ? entries[head].data : '0;

    assign lookup_hit  = |look_match;
    assign lookup_data = lookup_hit ? entries[look_idx].data : '0;

    assign flush_done  = flush && (count == '0) && (state == IDLE);

endmodule
